simplez_ram_arbiter: RTL and testbench
======================================

# simplez_ram_arbiter

Two-master arbiter sharing the single-port synchronous program/data RAM of the Simplez core. Master 0 is the UART program loader/debugger; master 1 is the CPU control unit. It registers grant decisions, drives the RAM port, and returns read data with a valid strobe. Optional lock bursts are bounded by a fairness counter.

## Interface

- AW, 9: RAM address width.
- DW, 12: RAM data width.
- MAX_BURST, 8: maximum consecutive locked grants to one master while the other is requesting; legal range 1..255.

- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- mN_req  in  1  access request; N = 0, 1. Held, with all qualifiers stable, until mN_gnt.
- mN_we  in  1  1 = write, 0 = read
- mN_lock  in  1  request to keep ownership for the next access
- mN_addr  in  AW  access address
- mN_wdata  in  DW  write data
- mN_gnt  out  1  one-cycle pulse; the access is performed on the RAM in this cycle
- mN_rvalid  out  1  one-cycle pulse; read data valid, one cycle after the read grant
- mN_rdata  out  DW  read data; equals ram_rdata, qualified by mN_rvalid
- ram_cs  out  1  RAM chip select
- ram_rw  out  1  1 = read, 0 = write
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data; registered by the RAM, valid one cycle after a read cs
- owner  out  2  00 = idle, 01 = m0, 10 = m1

## Operation

- States: IDLE, ACC0, ACC1. The state is registered. ACCn means master n owns the RAM in that cycle.
- In ACCn:
  - ram_cs=1.
  - ram_rw=!mn_we.
  - ram_addr and ram_wdata are taken from master n.
  - mn_gnt=1.
  - owner is set to n.
- In IDLE: ram_cs=0, ram_rw=1, and ram_addr and ram_wdata hold their last values.
- Next-state decision is evaluated every cycle.
  - Eligible request: mN_req=1. The current owner's req counts only if mN_lock=1 in its ACC cycle.
  - No eligible request: go to IDLE.
  - One eligible request: grant it.
  - Both eligible: pick the winner by the priority rule (see Configuration).
- Burst counter, 8 bits:
  - Increments on each consecutive ACC cycle of the same owner.
  - Cleared on an owner change or IDLE.
  - When the count reaches MAX_BURST-1 and the other master is eligible, the lock is overridden and the other master wins.
- Read return: registered per master. mn_rvalid is set in the cycle after ACCn when mn_we=0.
- Write: no return strobe. The gnt cycle is the commit cycle.

## Timing

- Reset values:
  - state IDLE, owner 00
  - all gnt and rvalid 0
  - ram_cs 0, ram_rw 1, ram_addr 0, ram_wdata 0
  - burst counter 0
  - round-robin last-owner = m1
- Latency:
  - req high at cycle t in IDLE: gnt at t+1.
  - Read data: rvalid at t+2.
- Throughput is one access per cycle.
  - Locked master: back-to-back ACC cycles, with new addr/we/wdata presented the cycle after each gnt.
  - Alternating masters: ACC0/ACC1 back-to-back, no IDLE cycle in between.
- An unlocked master must deassert req, or present a new request, in the cycle after gnt. Its req in the gnt cycle itself is ignored.
- Simultaneous req from both masters in IDLE: exactly one gnt at t+1. The loser is granted at t+2 if it is still requesting.
- rstn low mid-access: the next cycle is IDLE, and a pending rvalid is suppressed.
- mN_req dropped before gnt: no access is issued; this is legal.

## Configuration

- SIMPLEZ_ARB_RR_EN defined: round-robin. The master not granted most recently wins a tie, and the last-owner register updates on every ACC.
- SIMPLEZ_ARB_RR_EN undefined: fixed priority, m0 always wins a tie. The last-owner register is not instantiated.
- The burst limit applies in both modes.

## Structure

- Shared package simplez_pkg contains:
  - SIMPLEZ_AW=9 and SIMPLEZ_DW=12
  - state encoding (IDLE/ACC0/ACC1)
  - owner encoding
- One sub-module, simplez_arb_pick: combinational winner selection.
  - Inputs: the two eligible flags, last owner, burst-limit flag.
  - Output: next state.
  - Instantiated once.
- FSM, burst counter, RAM-port mux and rvalid registers live in the top.

## Test plan

- Reset, then m1 read at addr 0x005 with RAM content 0x1A3: m1_gnt at t+1, ram_cs=1, ram_rw=1, ram_addr=0x005; m1_rvalid at t+2 with m1_rdata=0x1A3.
- m0 write 0x7FF to 0x010, then m1 read of 0x010: m1_rdata=0x7FF.
- Both masters request in the same IDLE cycle:
  - Fixed priority (macro undefined): m0_gnt first, then m1_gnt the next cycle.
  - Round-robin (macro defined): first tie goes to m0, second tie to m1.
- m0 locked for 20 reads with m1 requesting, MAX_BURST=8: exactly 8 consecutive m0 gnts, then one m1 gnt, then m0 resumes; no IDLE cycle in between.
- m0 locked burst of 4 writes to 0x000..0x003, m1 idle: 4 consecutive gnts, owner=01 throughout, then IDLE with ram_cs=0.
- rstn asserted in the ACC1 cycle of a read: no m1_rvalid, owner=00, both gnts 0 the next cycle.

Source files
------------

// File: rtl/simplez_pkg.sv
// rtl/simplez_pkg.sv - shared widths, FSM state and owner encodings for the Simplez RAM arbiter
package simplez_pkg;

  localparam int SIMPLEZ_AW = 9;
  localparam int SIMPLEZ_DW = 12;

  // State values double as the owner field encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC0 = 2'b01,
    ST_ACC1 = 2'b10
  } state_t;

  localparam logic [1:0] OWNER_IDLE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b01;
  localparam logic [1:0] OWNER_M1   = 2'b10;

endpackage

// File: rtl/simplez_arb_pick.sv
// rtl/simplez_arb_pick.sv - combinational winner selection for the two-master RAM arbiter
module simplez_arb_pick
  import simplez_pkg::*;
(
  input  logic   elig0,
  input  logic   elig1,
  input  logic   last_owner,
  input  logic   burst_limit,
  input  state_t state,
  output state_t next_state
);

  always_comb begin
    next_state = ST_IDLE;
    if (elig0 && elig1) begin
      // A saturated burst hands the RAM to the other master regardless of priority.
      if (burst_limit && state == ST_ACC0)
        next_state = ST_ACC1;
      else if (burst_limit && state == ST_ACC1)
        next_state = ST_ACC0;
      else
        next_state = last_owner ? ST_ACC0 : ST_ACC1;
    end else if (elig0) begin
      next_state = ST_ACC0;
    end else if (elig1) begin
      next_state = ST_ACC1;
    end
  end

endmodule

// File: rtl/simplez_ram_arbiter.sv
// rtl/simplez_ram_arbiter.sv - two-master arbiter for the Simplez single-port RAM
// SIMPLEZ_ARB_RR_EN selects round-robin tie-breaking; undefined gives fixed m0 priority.
module simplez_ram_arbiter
  import simplez_pkg::*;
#(
  parameter int AW        = SIMPLEZ_AW,
  parameter int DW        = SIMPLEZ_DW,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_cs,
  output logic          ram_rw,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [1:0]    owner
);

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_t        state, next_state;
  logic [7:0]    burst_cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          elig0, elig1, last_owner, burst_limit;

  // The owner's own request only counts when it asked to keep the RAM.
  assign elig0       = m0_req && (state != ST_ACC0 || m0_lock);
  assign elig1       = m1_req && (state != ST_ACC1 || m1_lock);
  assign burst_limit = burst_cnt >= BURST_LAST;

`ifdef SIMPLEZ_ARB_RR_EN
  logic last_owner_q;
  always_ff @(posedge clk) begin
    if (!rstn)
      last_owner_q <= 1'b1;
    else if (state != ST_IDLE)
      last_owner_q <= (state == ST_ACC1);
  end
  assign last_owner = last_owner_q;
`else
  assign last_owner = 1'b1;
`endif

  simplez_arb_pick u_pick (
    .elig0       (elig0),
    .elig1       (elig1),
    .last_owner  (last_owner),
    .burst_limit (burst_limit),
    .state       (state),
    .next_state  (next_state)
  );

  always_ff @(posedge clk) begin
    if (!rstn)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    ram_cs    = 1'b0;
    ram_rw    = 1'b1;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    owner     = OWNER_IDLE;
    case (state)
      ST_ACC0: begin
        ram_cs    = 1'b1;
        ram_rw    = !m0_we;
        ram_addr  = m0_addr;
        ram_wdata = m0_wdata;
        m0_gnt    = 1'b1;
        owner     = OWNER_M0;
      end
      ST_ACC1: begin
        ram_cs    = 1'b1;
        ram_rw    = !m1_we;
        ram_addr  = m1_addr;
        ram_wdata = m1_wdata;
        m1_gnt    = 1'b1;
        owner     = OWNER_M1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      burst_cnt <= 8'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      if (state != ST_IDLE && next_state == state)
        burst_cnt <= (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;
      else
        burst_cnt <= 8'd0;
      addr_q    <= ram_addr;
      wdata_q   <= ram_wdata;
      m0_rvalid <= (state == ST_ACC0) && !m0_we;
      m1_rvalid <= (state == ST_ACC1) && !m1_we;
    end
  end

  assign m0_rdata = ram_rdata;
  assign m1_rdata = ram_rdata;

endmodule

// File: tb/tb_simplez_ram_arbiter.sv
// tb/tb_simplez_ram_arbiter.sv - directed table-driven bench for simplez_ram_arbiter (default fixed priority)
module tb_simplez_ram_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [8:0]  m0_addr, m1_addr, ram_addr;
  logic [11:0] m0_wdata, m1_wdata, ram_wdata, ram_rdata, m0_rdata, m1_rdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_cs, ram_rw;
  logic [1:0]  owner;
  logic [11:0] mem [0:511];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  simplez_ram_arbiter #(.AW(9), .DW(12), .MAX_BURST(8)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .owner(owner)
  );

  // Registered single-port RAM model
  always @(posedge clk) begin
    if (ram_cs) begin
      if (!ram_rw) mem[ram_addr] <= ram_wdata;
      else         ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    logic [2:0]  c0;   // {req, we, lock}
    logic [8:0]  a0;
    logic [11:0] d0;
    logic [2:0]  c1;
    logic [8:0]  a1;
    logic [11:0] d1;
    logic [7:0]  st;   // {g0, g1, v0, v1, owner, cs, rw}
    logic [8:0]  addr;
    logic [11:0] rd;
  } vec_t;

  vec_t tbl [0:20];

  function automatic vec_t mk(input logic [2:0] c0, input logic [8:0] a0, input logic [11:0] d0,
                              input logic [2:0] c1, input logic [8:0] a1, input logic [11:0] d1,
                              input logic [3:0] gv, input logic [1:0] own, input logic cs,
                              input logic rw, input logic [8:0] addr, input logic [11:0] rd);
    vec_t v;
    v.c0 = c0; v.a0 = a0; v.d0 = d0; v.c1 = c1; v.a1 = a1; v.d1 = d1;
    v.st = {gv, own, cs, rw}; v.addr = addr; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic [2:0] c0, input logic [8:0] a0, input logic [11:0] d0,
                       input logic [2:0] c1, input logic [8:0] a1, input logic [11:0] d1);
    {m0_req, m0_we, m0_lock} = c0; m0_addr = a0; m0_wdata = d0;
    {m1_req, m1_we, m1_lock} = c1; m1_addr = a1; m1_wdata = d1;
  endtask

  function automatic logic [7:0] status();
    return {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, owner, ram_cs, ram_rw};
  endfunction

  initial begin
    logic g0e, g1e, pg0, pg1;
    int   n0, g0_seen;

    for (int i = 0; i < 512; i++) mem[i] = 12'h000;
    mem[9'h005] = 12'h1A3;
    mem[9'h020] = 12'h222;
    mem[9'h021] = 12'h333;
    ram_rdata = 12'h000;

    tbl[0]  = mk(3'b000, 9'h000, 12'h000, 3'b100, 9'h005, 12'h000, 4'b0000, 2'd0, 1'b0, 1'b1, 9'h000, 12'h000);
    tbl[1]  = mk(3'b000, 9'h000, 12'h000, 3'b100, 9'h005, 12'h000, 4'b0100, 2'd2, 1'b1, 1'b1, 9'h005, 12'h000);
    tbl[2]  = mk(3'b000, 9'h000, 12'h000, 3'b000, 9'h000, 12'h000, 4'b0001, 2'd0, 1'b0, 1'b1, 9'h005, 12'h1A3);
    tbl[3]  = mk(3'b110, 9'h010, 12'h7FF, 3'b000, 9'h000, 12'h000, 4'b0000, 2'd0, 1'b0, 1'b1, 9'h005, 12'h000);
    tbl[4]  = mk(3'b110, 9'h010, 12'h7FF, 3'b000, 9'h000, 12'h000, 4'b1000, 2'd1, 1'b1, 1'b0, 9'h010, 12'h000);
    tbl[5]  = mk(3'b000, 9'h000, 12'h000, 3'b100, 9'h010, 12'h000, 4'b0000, 2'd0, 1'b0, 1'b1, 9'h010, 12'h000);
    tbl[6]  = mk(3'b000, 9'h000, 12'h000, 3'b100, 9'h010, 12'h000, 4'b0100, 2'd2, 1'b1, 1'b1, 9'h010, 12'h000);
    tbl[7]  = mk(3'b000, 9'h000, 12'h000, 3'b000, 9'h000, 12'h000, 4'b0001, 2'd0, 1'b0, 1'b1, 9'h010, 12'h7FF);
    tbl[8]  = mk(3'b100, 9'h020, 12'h000, 3'b100, 9'h021, 12'h000, 4'b0000, 2'd0, 1'b0, 1'b1, 9'h010, 12'h000);
    tbl[9]  = mk(3'b100, 9'h020, 12'h000, 3'b100, 9'h021, 12'h000, 4'b1000, 2'd1, 1'b1, 1'b1, 9'h020, 12'h000);
    tbl[10] = mk(3'b000, 9'h000, 12'h000, 3'b100, 9'h021, 12'h000, 4'b0110, 2'd2, 1'b1, 1'b1, 9'h021, 12'h222);
    tbl[11] = mk(3'b000, 9'h000, 12'h000, 3'b000, 9'h000, 12'h000, 4'b0001, 2'd0, 1'b0, 1'b1, 9'h021, 12'h333);
    tbl[12] = mk(3'b111, 9'h000, 12'h100, 3'b000, 9'h000, 12'h000, 4'b0000, 2'd0, 1'b0, 1'b1, 9'h021, 12'h000);
    tbl[13] = mk(3'b111, 9'h000, 12'h100, 3'b000, 9'h000, 12'h000, 4'b1000, 2'd1, 1'b1, 1'b0, 9'h000, 12'h000);
    tbl[14] = mk(3'b111, 9'h001, 12'h101, 3'b000, 9'h000, 12'h000, 4'b1000, 2'd1, 1'b1, 1'b0, 9'h001, 12'h000);
    tbl[15] = mk(3'b111, 9'h002, 12'h102, 3'b000, 9'h000, 12'h000, 4'b1000, 2'd1, 1'b1, 1'b0, 9'h002, 12'h000);
    tbl[16] = mk(3'b110, 9'h003, 12'h103, 3'b000, 9'h000, 12'h000, 4'b1000, 2'd1, 1'b1, 1'b0, 9'h003, 12'h000);
    tbl[17] = mk(3'b000, 9'h000, 12'h000, 3'b000, 9'h000, 12'h000, 4'b0000, 2'd0, 1'b0, 1'b1, 9'h003, 12'h000);
    tbl[18] = mk(3'b000, 9'h000, 12'h000, 3'b100, 9'h002, 12'h000, 4'b0000, 2'd0, 1'b0, 1'b1, 9'h003, 12'h000);
    tbl[19] = mk(3'b000, 9'h000, 12'h000, 3'b100, 9'h002, 12'h000, 4'b0100, 2'd2, 1'b1, 1'b1, 9'h002, 12'h000);
    tbl[20] = mk(3'b000, 9'h000, 12'h000, 3'b000, 9'h000, 12'h000, 4'b0001, 2'd0, 1'b0, 1'b1, 9'h002, 12'h102);

    rstn = 1'b0;
    drive(3'b000, 9'h000, 12'h000, 3'b000, 9'h000, 12'h000);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    chk("reset_wdata", 32'(ram_wdata), 32'h000);
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].c0, tbl[i].a0, tbl[i].d0, tbl[i].c1, tbl[i].a1, tbl[i].d1);
      @(negedge clk);
      chk($sformatf("vec%0d_status", i), 32'(status()), 32'(tbl[i].st));
      chk($sformatf("vec%0d_addr", i), 32'(ram_addr), 32'(tbl[i].addr));
      if (tbl[i].st[5]) chk($sformatf("vec%0d_m0_rdata", i), 32'(m0_rdata), 32'(tbl[i].rd));
      if (tbl[i].st[4]) chk($sformatf("vec%0d_m1_rdata", i), 32'(m1_rdata), 32'(tbl[i].rd));
      @(posedge clk); #1;
    end

    // Locked m0 read burst of 20 against a waiting m1 read: 8 m0, 1 m1, 12 m0, no gaps
    n0 = 0; g0_seen = 0; pg0 = 1'b0; pg1 = 1'b0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      g0e = (cyc >= 1 && cyc <= 8) || (cyc >= 10 && cyc <= 21);
      g1e = (cyc == 9);
      drive({n0 < 20, 1'b0, n0 < 19}, 9'(9'h040 + n0), 12'h000, {cyc <= 9, 2'b00}, 9'h080, 12'h000);
      @(negedge clk);
      chk($sformatf("burst%0d_status", cyc), 32'(status()),
          32'({g0e, g1e, pg0, pg1, g0e ? 2'd1 : (g1e ? 2'd2 : 2'd0), g0e | g1e, 1'b1}));
      if (g0e | g1e)
        chk($sformatf("burst%0d_addr", cyc), 32'(ram_addr), g0e ? 32'(9'h040 + n0) : 32'h080);
      if (m0_gnt) g0_seen++;
      if (g0e) n0++;
      pg0 = g0e; pg1 = g1e;
      @(posedge clk); #1;
    end
    chk("burst_m0_gnt_total", 32'(g0_seen), 32'd20);

    // Reset in the ACC1 cycle of an m1 read
    drive(3'b000, 9'h000, 12'h000, 3'b100, 9'h005, 12'h000);
    @(negedge clk);
    chk("rst_pre_idle", 32'(status()), 32'h01);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_acc1_gnt", 32'(status()), 32'h4B);
    rstn = 1'b0;
    drive(3'b000, 9'h000, 12'h000, 3'b000, 9'h000, 12'h000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_after_status", 32'(status()), 32'h01);
    chk("rst_after_addr", 32'(ram_addr), 32'h000);
    rstn = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_released_status", 32'(status()), 32'h01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
